mlaccel_qpi_host: RTL and testbench



---
 rtl/mlaccel_qpi_host.sv | 141 ++++++++++++++
 tb/tb_mlaccel_qpi_host.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlaccel_qpi_host.sv
// QPI host: turns a byte-slot command stream into one csb-framed nibble-bus transaction.
// Optional MLACCEL_QPI_HOST_RDSYNC_EN adds a 2-flop synchronizer on qpi_io_di with later read sampling.
module mlaccel_qpi_host #(
   parameter int CLKDIV  = 4,
   parameter int CSB_GAP = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_data,
   input  logic       cmd_read,
   input  logic       cmd_last,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       qpi_csb,
   output logic       qpi_clk,
   input  logic [3:0] qpi_io_di,
   output logic [3:0] qpi_io_do,
   output logic [3:0] qpi_io_oe
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HI   = 3'd1;
   localparam logic [2:0] S_LO   = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;

   localparam int CMAX = (CLKDIV > CSB_GAP) ? CLKDIV : CSB_GAP;
   localparam int CW   = $clog2(CMAX + 1);

   logic [2:0]    state, state_nx;
   logic [CW-1:0] count;
   logic [7:0]    data_r;
   logic          read_r, last_r, hold_r;
   logic [3:0]    rd_hi;
   logic          hs, div_end, gap_end, rsp_block_nx, drive;

   // cmd valid/ready: a slot transfers on a clock edge where both are high; cmd_valid may wait
   // indefinitely while cmd_ready is low and the offered slot is neither consumed nor dropped.
   assign hs      = cmd_valid && cmd_ready;
   assign div_end = (count == CW'(CLKDIV - 1));
   assign gap_end = (count == CW'(CSB_GAP - 1));

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (hs) state_nx = S_HI;
         S_WAIT:  if (hs) state_nx = S_HI;
         S_HI:    if (div_end) state_nx = S_LO;
         S_LO:    if (div_end) state_nx = last_r ? S_GAP : S_WAIT;
         S_GAP:   if (gap_end) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

`ifdef MLACCEL_QPI_HOST_RDSYNC_EN
   logic [3:0] di_s1, di_s2;
   logic [1:0] pend, pend_nx;

   // pend counts down the two extra cycles between the falling edge and the low-nibble sample
   always_comb begin
      pend_nx = pend;
      if (state == S_LO && div_end && read_r) pend_nx = 2'd2;
      else if (pend != 2'd0)                  pend_nx = pend - 2'd1;
   end
   assign rsp_block_nx = (pend_nx != 2'd0);
`else
   assign rsp_block_nx = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         count     <= '0;
         data_r    <= 8'h00;
         read_r    <= 1'b0;
         last_r    <= 1'b0;
         hold_r    <= 1'b0;
         rd_hi     <= 4'h0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
         qpi_csb   <= 1'b1;
         qpi_clk   <= 1'b0;
`ifdef MLACCEL_QPI_HOST_RDSYNC_EN
         di_s1     <= 4'h0;
         di_s2     <= 4'h0;
         pend      <= 2'd0;
`endif
      end else begin
         state     <= state_nx;
         hold_r    <= 1'b0;
         rsp_valid <= 1'b0;
         cmd_ready <= ((state_nx == S_IDLE) || (state_nx == S_WAIT)) && !rsp_block_nx;
         if (state_nx != state)
            count <= '0;
         else if (state == S_HI || state == S_LO || state == S_GAP)
            count <= count + CW'(1);
         if (hs) begin
            data_r  <= cmd_data;
            read_r  <= cmd_read;
            last_r  <= cmd_last;
            qpi_csb <= 1'b0;
         end
         if (state == S_HI && div_end) begin
            qpi_clk <= 1'b1;
`ifndef MLACCEL_QPI_HOST_RDSYNC_EN
            if (read_r) rd_hi <= qpi_io_di;
`endif
         end
         if (state == S_LO && div_end) begin
            qpi_clk <= 1'b0;
            hold_r  <= 1'b1;
            if (last_r) qpi_csb <= 1'b1;
`ifndef MLACCEL_QPI_HOST_RDSYNC_EN
            if (read_r) begin
               rsp_valid <= 1'b1;
               rsp_data  <= {rd_hi, qpi_io_di};
            end
`endif
         end
`ifdef MLACCEL_QPI_HOST_RDSYNC_EN
         di_s1 <= qpi_io_di;
         di_s2 <= di_s1;
         pend  <= pend_nx;
         if (state == S_LO && count == CW'(1) && read_r) rd_hi <= di_s2;
         if (pend == 2'd1) begin
            rsp_valid <= 1'b1;
            rsp_data  <= {rd_hi, di_s2};
         end
`endif
      end
   end

   // hold_r keeps the low nibble driven for one cycle past the falling edge
   assign drive     = (state == S_HI || state == S_LO || hold_r) && !read_r;
   assign qpi_io_oe = {4{drive}};
   assign qpi_io_do = (state == S_HI || (state == S_LO && count == '0)) ? data_r[7:4] : data_r[3:0];
   assign busy      = (state != S_IDLE);
endmodule

// File: tb/tb_mlaccel_qpi_host.sv
// Directed bench for mlaccel_qpi_host: bus monitor plus responder, slot and response scoreboards.
module tb_mlaccel_qpi_host;
  localparam int CLKDIV  = 4;
  localparam int CSB_GAP = 8;
  localparam int RD_LAT  = 2 * CLKDIV + 1;
  localparam int SLOT_T  = 2 * CLKDIV + 1;

  logic       clock, reset;
  logic       cmd_valid, cmd_ready, cmd_read, cmd_last;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy, qpi_csb, qpi_clk;
  logic [3:0] qpi_io_di, qpi_io_do, qpi_io_oe;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];      // {read, byte} per slot in flight
  logic [7:0] rsp_q[$];      // expected captured read bytes
  int         lat_q[$];      // handshake cycle of each pending read

  logic       prev_clk, prev_csb;
  logic [3:0] cap_hi, cap_oe;
  logic [8:0] slot_e;
  logic [7:0] rsp_e;
  int         lat_e;
  int         rise_cnt = 0;
  int         csb_rise_cnt = 0;

  mlaccel_qpi_host #(.CLKDIV(CLKDIV), .CSB_GAP(CSB_GAP)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_read  (cmd_read),
    .cmd_last  (cmd_last),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .qpi_csb   (qpi_csb),
    .qpi_clk   (qpi_clk),
    .qpi_io_di (qpi_io_di),
    .qpi_io_do (qpi_io_do),
    .qpi_io_oe (qpi_io_oe)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic send(input logic [7:0] d, input logic rd, input logic last, output int hs_cyc);
    int n;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_read  = rd;
    cmd_last  = last;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("handshake_in_time", n < 500, 1);
    hs_cyc = cyc;
    exp_q.push_back({rd, d});
    if (rd) begin
      rsp_q.push_back(d);
      lat_q.push_back(cyc);
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_read  = 1'b0;
    cmd_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("idle_in_time", n < 1000, 1);
  endtask

  // bus monitor, read responder and scoreboard
  always @(negedge clock) begin
    if (reset) begin
      prev_clk  = 1'b0;
      prev_csb  = 1'b1;
      qpi_io_di = 4'h0;
    end else begin
      if (!prev_clk && qpi_clk) begin
        rise_cnt++;
        cap_hi = qpi_io_do;
        cap_oe = qpi_io_oe;
      end
      if (prev_clk && !qpi_clk) begin
        chk("slot_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          slot_e = exp_q.pop_front();
          if (slot_e[8]) begin
            chk("rd_oe_at_rise", cap_oe, 4'h0);
            chk("rd_oe_at_fall", qpi_io_oe, 4'h0);
          end else begin
            chk("wr_byte", {cap_hi, qpi_io_do}, slot_e[7:0]);
            chk("wr_oe_at_rise", cap_oe, 4'hF);
            chk("wr_oe_at_fall", qpi_io_oe, 4'hF);
          end
        end
      end
      if (!prev_csb && qpi_csb) csb_rise_cnt++;
      prev_clk = qpi_clk;
      prev_csb = qpi_csb;
      if (rsp_valid) begin
        chk("rsp_expected", rsp_q.size() > 0, 1);
        if (rsp_q.size() > 0) begin
          rsp_e = rsp_q.pop_front();
          lat_e = lat_q.pop_front();
          chk("rsp_data", rsp_data, rsp_e);
          chk("rsp_latency", cyc - lat_e, RD_LAT);
        end
      end
      if (exp_q.size() > 0 && exp_q[0][8])
        qpi_io_di = qpi_clk ? exp_q[0][3:0] : exp_q[0][7:4];
      else
        qpi_io_di = 4'h0;
    end
  end

  // directed sequence
  initial begin
    int n, g, h0, h1, h2, r0, c0, bad;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_read  = 1'b0;
    cmd_last  = 1'b0;
    qpi_io_di = 4'h0;
    repeat (3) @(negedge clock);
    chk("rst_csb", qpi_csb, 1);
    chk("rst_clk", qpi_clk, 0);
    chk("rst_oe", qpi_io_oe, 4'h0);
    chk("rst_do", qpi_io_do, 4'h0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_release", cmd_ready, 1);

    // single write 0x20, csb framing and gap
    send(8'h20, 1'b0, 1'b1, h0);
    @(negedge clock);
    n = 0;
    while (qpi_csb === 1'b0 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("csb_low_cycles", n, 2 * CLKDIV);
    g = 0;
    while (busy && qpi_csb && g < 100) begin
      g++;
      @(negedge clock);
    end
    chk("csb_gap_cycles", g, CSB_GAP);
    chk("idle_csb", qpi_csb, 1);
    chk("idle_ready", cmd_ready, 1);

    // single read returning 0xC3
    send(8'hC3, 1'b1, 1'b1, h0);
    wait_idle();

    // back-to-back writes in one frame
    r0 = rise_cnt;
    c0 = csb_rise_cnt;
    send(8'h25, 1'b0, 1'b0, h0);
    send(8'h34, 1'b0, 1'b0, h1);
    send(8'h12, 1'b0, 1'b1, h2);
    wait_idle();
    chk("b2b_spacing_1", h1 - h0, SLOT_T);
    chk("b2b_spacing_2", h2 - h1, SLOT_T);
    chk("b2b_rises", rise_cnt - r0, 3);
    chk("b2b_csb_rises", csb_rise_cnt - c0, 1);

    // host stall between slots
    send(8'h5A, 1'b0, 1'b0, h0);
    repeat (2 * CLKDIV + 2) @(negedge clock);
    r0 = rise_cnt;
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (qpi_csb !== 1'b0 || qpi_clk !== 1'b0) bad++;
    end
    chk("stall_bus_quiet", bad, 0);
    chk("stall_no_edges", rise_cnt - r0, 0);
    chk("stall_ready", cmd_ready, 1);
    chk("stall_busy", busy, 1);
    send(8'hA7, 1'b0, 1'b1, h1);
    wait_idle();
    chk("stall_resume_csb", qpi_csb, 1);

    // mixed frame: write command then two reads
    send(8'h22, 1'b0, 1'b0, h0);
    send(8'h11, 1'b1, 1'b0, h1);
    send(8'h22, 1'b1, 1'b1, h2);
    wait_idle();
    send(8'h00, 1'b1, 1'b1, h0);
    wait_idle();

    // async reset in the middle of LO for 0xA5
    send(8'hA5, 1'b0, 1'b1, h0);
    n = 0;
    while (qpi_clk !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("reach_lo", qpi_clk, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_csb", qpi_csb, 1);
    chk("midrst_clk", qpi_clk, 0);
    chk("midrst_oe", qpi_io_oe, 4'h0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_ready_after", cmd_ready, 1);

    // frame after reset completes normally
    send(8'h3C, 1'b0, 1'b1, h0);
    wait_idle();
    repeat (4) @(negedge clock);
    chk("slot_q_drained", exp_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
